// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches a 16-bit instruction, decodes it and
// sequences register, PC and data-memory strobes through FETCH/DECODE/EXEC/MEM/HALT.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        zero_flag,
  output logic        imem_req,
  output logic [15:0] ir,
  output logic        pc_en,
  output logic        jmp,
  output logic [15:0] offset,
  output logic [2:0]  alu_op,
  output logic        reg_we,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_LDI   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t      state, state_next;
  logic [15:0] ir_q, ir_next;
  logic [3:0]  opcode;

  assign opcode = ir_q[15:12];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ir_q  <= 16'h0000;
    end else begin
      state <= state_next;
      ir_q  <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    ir_next    = ir_q;
    imem_req   = 1'b0;
    pc_en      = 1'b0;
    jmp        = 1'b0;
    alu_op     = 3'd0;
    reg_we     = 1'b0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    halted     = 1'b0;
    ir         = ir_q;
    offset     = {{8{ir_q[7]}}, ir_q[7:0]};

    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_next    = instr_in;
          state_next = DECODE;
        end
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        state_next = FETCH;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            reg_we = 1'b1;
            pc_en  = 1'b1;
            alu_op = opcode[2:0] - 3'd1;
          end
          OP_LDI: begin
            reg_we = 1'b1;
            pc_en  = 1'b1;
            alu_op = 3'd5;
          end
          OP_JMP: jmp = 1'b1;
          OP_JZ: begin
            jmp   = zero_flag;
            pc_en = ~zero_flag;
          end
          OP_LOAD, OP_STORE: state_next = MEM;
          OP_HALT: state_next = HALT;
          default: pc_en = 1'b1;
        endcase
      end
      MEM: begin
        // Only LOAD and STORE reach MEM, so anything not LOAD is a store.
        dmem_re = (opcode == OP_LOAD);
        dmem_we = (opcode != OP_LOAD);
        if (dmem_ready) begin
          pc_en      = 1'b1;
          reg_we     = (opcode == OP_LOAD);
          state_next = FETCH;
        end
      end
      HALT: halted = 1'b1;
      default: state_next = FETCH;
    endcase

    // Reset blanks every output in the same cycle, before the state register clears.
    if (reset) begin
      imem_req = 1'b0;
      pc_en    = 1'b0;
      jmp      = 1'b0;
      alu_op   = 3'd0;
      reg_we   = 1'b0;
      dmem_re  = 1'b0;
      dmem_we  = 1'b0;
      halted   = 1'b0;
      ir       = 16'h0000;
      offset   = 16'h0000;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-instruction cycle model compared
// every cycle, plus hand-computed literal checks on the directed scenarios.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr_in = 16'h0000;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        zero_flag = 1'b0;
  logic        imem_req, pc_en, jmp, reg_we, dmem_re, dmem_we, halted;
  logic [15:0] ir, offset;
  logic [2:0]  alu_op;

  int checks = 0;
  int failures = 0;

  // Model: position within the current instruction (0 fetch, 1 decode, 2 execute, 3 memory wait)
  int          m_cycle = 0;
  logic [15:0] m_ir = 16'h0000;
  bit          m_halted = 1'b0;

  control_unit dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .zero_flag(zero_flag), .imem_req(imem_req), .ir(ir),
    .pc_en(pc_en), .jmp(jmp), .offset(offset), .alu_op(alu_op), .reg_we(reg_we),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] pack(input logic req, input logic [15:0] ir_v, input logic pc,
                                       input logic j, input logic [15:0] off, input logic [2:0] op,
                                       input logic we, input logic re, input logic wr, input logic h);
    return {req, ir_v, pc, j, off, op, we, re, wr, h};
  endfunction

  // Per-cycle compare against the model, then advance the model across the coming edge.
  initial begin
    forever begin
      logic        e_req, e_pc, e_jmp, e_we, e_re, e_wr, e_halt;
      logic [15:0] e_ir, e_off;
      logic [2:0]  e_op;
      int          op, sv;
      @(negedge clk);
      #2;
      e_req = 0; e_pc = 0; e_jmp = 0; e_we = 0; e_re = 0; e_wr = 0; e_halt = 0;
      e_op = 0; e_ir = 0; e_off = 0;
      op = int'(m_ir[15:12]);
      if (!reset) begin
        e_ir = m_ir;
        sv = int'(m_ir[7:0]);
        if (sv >= 128) sv = sv - 256;
        e_off = 16'(sv);
        if (m_halted) e_halt = 1;
        else if (m_cycle == 0) e_req = 1;
        else if (m_cycle == 2) begin
          if (op >= 1 && op <= 5) begin e_we = 1; e_pc = 1; e_op = 3'(op - 1); end
          else if (op == 8) begin e_we = 1; e_pc = 1; e_op = 3'd5; end
          else if (op == 9) e_jmp = 1;
          else if (op == 10) begin e_jmp = zero_flag; e_pc = !zero_flag; end
          else if (op != 6 && op != 7 && op != 15) e_pc = 1;
        end else if (m_cycle == 3) begin
          if (op == 6) e_re = 1; else e_wr = 1;
          if (dmem_ready) begin e_pc = 1; e_we = (op == 6); end
        end
      end
      check_output("cycle_outputs",
                   64'(pack(imem_req, ir, pc_en, jmp, offset, alu_op, reg_we, dmem_re, dmem_we, halted)),
                   64'(pack(e_req, e_ir, e_pc, e_jmp, e_off, e_op, e_we, e_re, e_wr, e_halt)));
      if (reset) begin
        m_cycle = 0; m_ir = 16'h0000; m_halted = 0;
      end else if (!m_halted) begin
        if (m_cycle == 0) begin
          if (imem_ready) begin m_ir = instr_in; m_cycle = 1; end
        end else if (m_cycle == 1) m_cycle = 2;
        else if (m_cycle == 2) begin
          if (op == 6 || op == 7) m_cycle = 3;
          else if (op == 15) m_halted = 1;
          else m_cycle = 0;
        end else if (dmem_ready) m_cycle = 0;
      end
    end
  end

  task automatic apply_stimulus(input logic rst, input logic [15:0] instr, input logic irdy,
                                input logic drdy, input logic zf);
    @(negedge clk);
    reset = rst; instr_in = instr; imem_ready = irdy; dmem_ready = drdy; zero_flag = zf;
    #3;
  endtask

  // Fetch, decode and execute one instruction, with stray readies and junk on instr_in.
  task automatic run_plain(input logic [15:0] instr, input logic zf);
    apply_stimulus(0, instr, 1, 0, zf);
    apply_stimulus(0, 16'hFFFF, 1, 1, zf);
    apply_stimulus(0, 16'hFFFF, 1, 1, zf);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    apply_stimulus(1, 16'h1234, 1, 1, 1);
    check_output("reset_imem_req", 64'(imem_req), 64'h0);
    apply_stimulus(1, 16'h1234, 1, 1, 1);
    check_output("reset_halted", 64'(halted), 64'h0);
    apply_stimulus(0, 16'h1234, 0, 0, 0);
    check_output("release_imem_req", 64'(imem_req), 64'h1);
    apply_stimulus(0, 16'h1234, 0, 0, 0);
    check_output("fetch_wait_ir", 64'(ir), 64'h0);

    // ADD
    apply_stimulus(0, 16'h1123, 1, 0, 0);
    check_output("add_fetch_req", 64'(imem_req), 64'h1);
    apply_stimulus(0, 16'h0000, 0, 0, 0);
    check_output("add_ir", 64'(ir), 64'h1123);
    apply_stimulus(0, 16'h0000, 0, 0, 0);
    check_output("add_exec", 64'({reg_we, pc_en, alu_op}), 64'({1'b1, 1'b1, 3'd0}));
    apply_stimulus(0, 16'h0000, 0, 0, 0);
    check_output("add_back_fetch", 64'({imem_req, pc_en}), 64'({1'b1, 1'b0}));
    apply_stimulus(0, 16'h0000, 0, 0, 0);

    run_plain(16'h2456, 0);
    run_plain(16'h3ABC, 1);
    run_plain(16'h4001, 0);
    run_plain(16'h5F0F, 0);
    check_output("xor_alu_op", 64'(alu_op), 64'h4);
    run_plain(16'h8080, 0);
    check_output("ldi_alu_op", 64'({reg_we, alu_op}), 64'({1'b1, 3'd5}));
    run_plain(16'h0000, 1);
    run_plain(16'hB0C3, 0);
    check_output("illegal_exec", 64'({pc_en, reg_we, alu_op}), 64'({1'b1, 1'b0, 3'd0}));
    run_plain(16'hE111, 1);

    // JMP and JZ
    run_plain(16'h90FE, 0);
    check_output("jmp_exec", 64'({jmp, pc_en, offset}), 64'({1'b1, 1'b0, 16'hFFFE}));
    run_plain(16'hA005, 1);
    check_output("jz_taken", 64'({jmp, pc_en, offset}), 64'({1'b1, 1'b0, 16'h0005}));
    run_plain(16'hA005, 0);
    check_output("jz_not_taken", 64'({jmp, pc_en}), 64'({1'b0, 1'b1}));

    // LOAD with three wait cycles
    run_plain(16'h6000, 0);
    check_output("load_exec", 64'({pc_en, dmem_re}), 64'h0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 16'h1123, 1, 0, 0);
      check_output("load_wait", 64'({dmem_re, reg_we, pc_en}), 64'({1'b1, 1'b0, 1'b0}));
    end
    apply_stimulus(0, 16'h1123, 1, 1, 0);
    check_output("load_done", 64'({dmem_re, reg_we, pc_en}), 64'({1'b1, 1'b1, 1'b1}));

    // STORE completing immediately
    run_plain(16'h7012, 0);
    apply_stimulus(0, 16'h0000, 0, 1, 0);
    check_output("store_done", 64'({dmem_we, reg_we, pc_en}), 64'({1'b1, 1'b0, 1'b1}));

    // STORE interrupted by reset in MEM
    run_plain(16'h7034, 0);
    apply_stimulus(0, 16'h0000, 0, 0, 0);
    check_output("store_wait", 64'(dmem_we), 64'h1);
    apply_stimulus(1, 16'h0000, 0, 0, 0);
    check_output("store_reset_we", 64'(dmem_we), 64'h0);
    apply_stimulus(0, 16'h0000, 0, 0, 0);
    check_output("store_restart", 64'({imem_req, ir}), 64'({1'b1, 16'h0000}));

    // HALT, then reset out of it
    run_plain(16'hF000, 0);
    check_output("halt_exec_pc", 64'(pc_en), 64'h0);
    for (int i = 0; i < 10; i++) apply_stimulus(0, 16'h1123, 1, 1, 1);
    check_output("halt_hold", 64'({halted, imem_req, pc_en}), 64'({1'b1, 1'b0, 1'b0}));
    apply_stimulus(1, 16'h1123, 1, 1, 1);
    check_output("halt_reset", 64'({halted, imem_req}), 64'h0);
    apply_stimulus(0, 16'h0000, 0, 0, 0);
    check_output("halt_release_req", 64'({imem_req, halted}), 64'({1'b1, 1'b0}));
    run_plain(16'h1123, 0);
    apply_stimulus(0, 16'h0000, 0, 0, 0);

    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
